// File: rtl/fp_fmt_pkg.sv
// Shared FP8 format constants, post-normalizer FSM encoding and a small width helper.
package fp_fmt_pkg;

  localparam int unsigned EXP_WIDTH      = 4;
  localparam int unsigned MANTISSA_WIDTH = 3;
  localparam int unsigned SIGN_WIDTH     = 1;
  localparam int unsigned FP_WIDTH       = SIGN_WIDTH + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int unsigned ALIGNED_WIDTH  = SIGN_WIDTH + MANTISSA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } pn_state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/post_norm_if.sv
// Input (aligned vector) and output (packed FP vector) handshake bundle for post_norm.
interface post_norm_if #(
  parameter int unsigned EXP_WIDTH        = fp_fmt_pkg::EXP_WIDTH,
  parameter int unsigned MANTISSA_WIDTH   = fp_fmt_pkg::MANTISSA_WIDTH,
  parameter int unsigned SIGN_WIDTH       = fp_fmt_pkg::SIGN_WIDTH,
  parameter int unsigned FP_WIDTH         = fp_fmt_pkg::FP_WIDTH,
  parameter int unsigned MACRO_DATA_WIDTH = 128
);

  localparam int unsigned AW = SIGN_WIDTH + MANTISSA_WIDTH + 1;

  logic [EXP_WIDTH-1:0]                 exp_max;
  logic [MACRO_DATA_WIDTH*AW-1:0]       mantissa_plus_aligned;
  logic                                 aligned_vld;
  logic                                 aligned_rdy;
  logic [MACRO_DATA_WIDTH*FP_WIDTH-1:0] data_out;
  logic                                 data_out_vld;
  logic                                 data_out_rdy;

  modport master (
    output exp_max, mantissa_plus_aligned, aligned_vld, data_out_rdy,
    input  aligned_rdy, data_out, data_out_vld
  );

  modport slave (
    input  exp_max, mantissa_plus_aligned, aligned_vld, data_out_rdy,
    output aligned_rdy, data_out, data_out_vld
  );

endinterface

// File: rtl/fp_renorm_lane.sv
// One-element renormalizer: leading-one detect, left shift, exponent subtract, underflow.
// POST_NORM_SUBNORMAL_EN defined: underflow yields subnormals; otherwise flush to signed zero.
module fp_renorm_lane #(
  parameter int unsigned EXP_WIDTH      = fp_fmt_pkg::EXP_WIDTH,
  parameter int unsigned MANTISSA_WIDTH = fp_fmt_pkg::MANTISSA_WIDTH,
  parameter int unsigned SIGN_WIDTH     = fp_fmt_pkg::SIGN_WIDTH
) (
  input  logic [SIGN_WIDTH+MANTISSA_WIDTH:0]            aligned_elem,
  input  logic [EXP_WIDTH-1:0]                          exp_max,
  output logic [SIGN_WIDTH+EXP_WIDTH+MANTISSA_WIDTH-1:0] fp_c
);

  localparam int unsigned PW = fp_fmt_pkg::clog2_min1(MANTISSA_WIDTH + 1);
  localparam int unsigned CW = ((EXP_WIDTH > PW) ? EXP_WIDTH : PW) + 1;

  logic [SIGN_WIDTH-1:0]     sign_c;
  logic [MANTISSA_WIDTH:0]   mag_c;
  logic [PW-1:0]             lead_c;
  logic [PW-1:0]             shift_c;
  logic                      underflow_c;
  logic [MANTISSA_WIDTH:0]   norm_shifted_c;
  logic [EXP_WIDTH-1:0]      exp_c;
  logic [MANTISSA_WIDTH-1:0] mant_c;
`ifdef POST_NORM_SUBNORMAL_EN
  logic [MANTISSA_WIDTH:0]   sub_shifted_c;
`endif

  assign sign_c = aligned_elem[SIGN_WIDTH+MANTISSA_WIDTH -: SIGN_WIDTH];
  assign mag_c  = aligned_elem[MANTISSA_WIDTH:0];

  // Highest set bit of the magnitude wins.
  always_comb begin
    lead_c = '0;
    for (int i = 0; i <= int'(MANTISSA_WIDTH); i++) begin
      if (mag_c[i]) lead_c = PW'(i);
    end
  end

  assign shift_c        = PW'(MANTISSA_WIDTH) - lead_c;
  assign underflow_c    = CW'(shift_c) >= CW'(exp_max);
  assign norm_shifted_c = mag_c << shift_c;

`ifdef POST_NORM_SUBNORMAL_EN
  // With exp_max==0 the element sits one binade below the subnormal scale.
  assign sub_shifted_c = (exp_max != '0) ? (mag_c << (exp_max - EXP_WIDTH'(1)))
                                         : (mag_c >> 1);
`endif

  always_comb begin
    exp_c  = '0;
    mant_c = '0;
    if (mag_c != '0) begin
      if (!underflow_c) begin
        exp_c  = exp_max - EXP_WIDTH'(shift_c);
        mant_c = norm_shifted_c[MANTISSA_WIDTH-1:0];
      end else begin
`ifdef POST_NORM_SUBNORMAL_EN
        mant_c = sub_shifted_c[MANTISSA_WIDTH-1:0];
`else
        mant_c = '0;
`endif
      end
    end
  end

  assign fp_c = {sign_c, exp_c, mant_c};

endmodule

// File: rtl/post_norm.sv
// Block-exponent to packed FP post-normalizer: captures one aligned vector, converts it
// LANES_PER_CYCLE elements per cycle, then holds the packed result until accepted.
module post_norm #(
  parameter int unsigned EXP_WIDTH        = fp_fmt_pkg::EXP_WIDTH,
  parameter int unsigned MANTISSA_WIDTH   = fp_fmt_pkg::MANTISSA_WIDTH,
  parameter int unsigned SIGN_WIDTH       = fp_fmt_pkg::SIGN_WIDTH,
  parameter int unsigned FP_WIDTH         = fp_fmt_pkg::FP_WIDTH,
  parameter int unsigned MACRO_DATA_WIDTH = 128,
  parameter int unsigned LANES_PER_CYCLE  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  post_norm_if.slave   bus
);

  localparam int unsigned AW    = SIGN_WIDTH + MANTISSA_WIDTH + 1;
  localparam int unsigned NCH   = MACRO_DATA_WIDTH / LANES_PER_CYCLE;
  localparam int unsigned CNT_W = fp_fmt_pkg::clog2_min1(NCH);
  localparam int unsigned CIW   = LANES_PER_CYCLE * AW;
  localparam int unsigned COW   = LANES_PER_CYCLE * FP_WIDTH;
  localparam int unsigned VEC_W = MACRO_DATA_WIDTH * AW;
  localparam int unsigned OUT_W = MACRO_DATA_WIDTH * FP_WIDTH;

  fp_fmt_pkg::pn_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EXP_WIDTH-1:0]  exp_max_q, exp_max_d;
  logic [VEC_W-1:0]      vec_q, vec_d;
  logic [OUT_W-1:0]      data_out_q, data_out_d;
  logic                  data_out_vld_q, data_out_vld_d;
  logic                  aligned_rdy_q, aligned_rdy_d;
  logic [CIW-1:0]        chunk_in_c;
  logic [COW-1:0]        chunk_out_c;

  assign chunk_in_c = vec_q[int'(cnt_q)*CIW +: CIW];

  // One renormalizer per lane, shared across chunks.
  for (genvar l = 0; l < int'(LANES_PER_CYCLE); l++) begin : g_lane
    fp_renorm_lane #(
      .EXP_WIDTH      (EXP_WIDTH),
      .MANTISSA_WIDTH (MANTISSA_WIDTH),
      .SIGN_WIDTH     (SIGN_WIDTH)
    ) u_lane (
      .aligned_elem (chunk_in_c[l*AW +: AW]),
      .exp_max      (exp_max_q),
      .fp_c         (chunk_out_c[l*FP_WIDTH +: FP_WIDTH])
    );
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_max_d  = exp_max_q;
    vec_d      = vec_q;
    data_out_d = data_out_q;
    case (state_q)
      fp_fmt_pkg::ST_IDLE: begin
        if (bus.aligned_vld) begin
          exp_max_d = bus.exp_max;
          vec_d     = bus.mantissa_plus_aligned;
          cnt_d     = '0;
          state_d   = fp_fmt_pkg::ST_CONV;
        end
      end
      fp_fmt_pkg::ST_CONV: begin
        data_out_d[int'(cnt_q)*COW +: COW] = chunk_out_c;
        if (cnt_q == CNT_W'(NCH - 1)) begin
          cnt_d   = '0;
          state_d = fp_fmt_pkg::ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      fp_fmt_pkg::ST_DONE: begin
        if (bus.data_out_rdy) state_d = fp_fmt_pkg::ST_IDLE;
      end
      default: state_d = fp_fmt_pkg::ST_IDLE;
    endcase
    data_out_vld_d = (state_d == fp_fmt_pkg::ST_DONE);
    aligned_rdy_d  = (state_d == fp_fmt_pkg::ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= fp_fmt_pkg::ST_IDLE;
      cnt_q          <= '0;
      exp_max_q      <= '0;
      vec_q          <= '0;
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
      aligned_rdy_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      exp_max_q      <= exp_max_d;
      vec_q          <= vec_d;
      data_out_q     <= data_out_d;
      data_out_vld_q <= data_out_vld_d;
      aligned_rdy_q  <= aligned_rdy_d;
    end
  end

  assign bus.aligned_rdy  = aligned_rdy_q;
  assign bus.data_out     = data_out_q;
  assign bus.data_out_vld = data_out_vld_q;

endmodule
